// File: rtl/valid_pipe_ctrl_rst_if.sv
// Handshake bundle for valid_pipe_ctrl_rst.
//   master : upstream/downstream side (drives flush, in_valid, in_data, out_ready)
//   slave  : the pipeline itself (drives in_ready, out_valid, out_data, count)
// Parameters: WIDTH (data bits), DEPTH (stages); CW is derived.
interface valid_pipe_ctrl_rst_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/valid_pipe_ctrl_rst.sv
// valid_pipe_ctrl_rst: WIDTH x DEPTH valid/ready register slice with
// bubble-collapsing backpressure, synchronous flush and an occupancy count.
// Only control state (stage valids, count, ready enable) is reset; the data
// registers are reset as well only when VALID_PIPE_DATA_RST_EN is defined.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : valid_pipe_ctrl_rst_if.slave
//           flush, in_valid/in_ready/in_data, out_valid/out_ready/out_data,
//           count (occupied stages, 0..DEPTH)
module valid_pipe_ctrl_rst #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  valid_pipe_ctrl_rst_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q;
  logic [WIDTH-1:0] d_q   [DEPTH];
  logic [WIDTH-1:0] d_nxt [DEPTH];
  logic [DEPTH-1:0] en;
  logic             ready_en_q;
  logic [CW-1:0]    count_q;
  logic             in_ready_c;
  logic             out_valid_c;
  logic             in_hs;
  logic             out_hs;

  // Advance chain: a stage moves if it is empty or the stage after it moves.
  always_comb begin : adv_chain
    logic carry;
    carry = bus.out_ready;
    en    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      carry = ~v_q[i] | carry;
      en[i] = carry;
    end
  end

  assign in_ready_c  = ready_en_q & en[0] & ~bus.flush;
  assign out_valid_c = v_q[DEPTH-1] & ~bus.flush;
  assign in_hs       = bus.in_valid & in_ready_c;
  assign out_hs      = out_valid_c & bus.out_ready;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = d_q[DEPTH-1];
  assign bus.count     = count_q;

  // Control state: ready enable, stage valids, occupancy.
  always_ff @(posedge clk or negedge rst_n) begin : ctrl_regs
    if (!rst_n) begin
      ready_en_q <= 1'b0;
      v_q        <= '0;
      count_q    <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (bus.flush) begin
        v_q     <= '0;
        count_q <= '0;
      end else begin
        if (en[0]) v_q[0] <= in_hs;
        for (int i = 1; i < DEPTH; i++) begin
          if (en[i]) v_q[i] <= v_q[i-1];
        end
        if (in_hs && !out_hs)      count_q <= count_q + CW'(1);
        else if (out_hs && !in_hs) count_q <= count_q - CW'(1);
      end
    end
  end

  // Next data: load from the previous stage whenever the stage advances;
  // contents under a cleared valid are don't-care.
  always_comb begin : data_next
    for (int i = 0; i < DEPTH; i++) begin
      d_nxt[i] = d_q[i];
    end
    if (en[0]) d_nxt[0] = bus.in_data;
    for (int i = 1; i < DEPTH; i++) begin
      if (en[i]) d_nxt[i] = d_q[i-1];
    end
  end

`ifdef VALID_PIPE_DATA_RST_EN
  // Data registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin : data_regs
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= d_nxt[i];
      end
    end
  end
`else
  // Data registers without reset.
  always_ff @(posedge clk) begin : data_regs
    for (int i = 0; i < DEPTH; i++) begin
      d_q[i] <= d_nxt[i];
    end
  end
`endif

endmodule

// File: tb/tb_valid_pipe_ctrl_rst.sv
// Self-checking bench for valid_pipe_ctrl_rst (WIDTH=8, DEPTH=4).
// Reference model: a queue of accepted items with their acceptance cycle.
// An item is visible at the output no earlier than DEPTH cycles after
// acceptance and no earlier than the cycle after its predecessor left.
module tb_valid_pipe_ctrl_rst;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst_n;

  valid_pipe_ctrl_rst_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  valid_pipe_ctrl_rst #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] q_data [$];
  int               q_acc  [$];
  int               last_pop = -1000;
  int               cyc      = 0;
  bit               rdy_en   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    q_data.delete();
    q_acc.delete();
    last_pop = -1000;
  endtask

  // One clock cycle: drive inputs after the edge, check, then advance the model.
  task automatic step(input logic iv, input logic [WIDTH-1:0] id,
                      input logic ordy, input logic fl);
    logic exp_ir, exp_ov, ihs, ohs;
    int   ready_at;
    @(posedge clk);
    cyc++;
    rdy_en = 1'b1;
    #1;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
    exp_ir = rdy_en && !fl && !(q_data.size() == DEPTH && !ordy);
    exp_ov = 1'b0;
    if (!fl && q_data.size() > 0) begin
      ready_at = q_acc[0] + DEPTH;
      if (last_pop + 1 > ready_at) ready_at = last_pop + 1;
      exp_ov = (cyc >= ready_at);
    end
    chk("in_ready", 32'(bus.in_ready), 32'(exp_ir));
    chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    chk("count", 32'(bus.count), 32'(q_data.size()));
    if (exp_ov) chk("out_data", 32'(bus.out_data), 32'(q_data[0]));
    ihs = iv && exp_ir;
    ohs = exp_ov && ordy;
    if (fl) begin
      model_clear();
    end else begin
      if (ohs) begin
        void'(q_data.pop_front());
        void'(q_acc.pop_front());
        last_pop = cyc;
      end
      if (ihs) begin
        q_data.push_back(id);
        q_acc.push_back(cyc);
      end
    end
  endtask

  // Assert reset in the middle of a cycle, hold it, then release mid-cycle.
  task automatic reset_mid();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_count", 32'(bus.count), 32'(0));
    chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
`ifdef VALID_PIPE_DATA_RST_EN
    chk("rst_out_data", 32'(bus.out_data), 32'(0));
`endif
    model_clear();
    rdy_en = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'(0));
    chk("rel_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rel_count", 32'(bus.count), 32'(0));
  endtask

  initial begin : timeout
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Power-on reset, release mid-cycle.
    #13;
    rst_n = 1'b1;
    #1;
    chk("por_in_ready", 32'(bus.in_ready), 32'(0));
    chk("por_out_valid", 32'(bus.out_valid), 32'(0));
    chk("por_count", 32'(bus.count), 32'(0));
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Back-to-back stream with out_ready high.
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
    repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Fill while blocked, overflow item held upstream, then drain.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    repeat (8) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Bubble collapse under backpressure.
    step(1'b1, 8'hA0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hB0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush with three items resident and handshakes requested.
    step(1'b1, 8'h61, 1'b0, 1'b0);
    step(1'b1, 8'h62, 1'b0, 1'b0);
    step(1'b1, 8'h63, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b1);
    repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);

    // Reset in the middle of a stream.
    for (int i = 0; i < 6; i++) step(1'b1, 8'hFF, 1'b1, 1'b0);
    reset_mid();
    repeat (3) step(1'b1, 8'(8'h80 + cyc), 1'b1, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      logic iv, ordy, fl;
      logic [WIDTH-1:0] dat;
      iv   = 1'($urandom_range(0, 1));
      dat  = 8'($urandom);
      ordy = 1'(($urandom % 10) < 7);
      fl   = 1'(($urandom % 32) == 0);
      step(iv, dat, ordy, fl);
      if (i == 150) reset_mid();
    end
    repeat (8) step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/valid_pipe_ctrl_rst.md
Name: valid_pipe_ctrl_rst

Overview:
- Parametrised WIDTH x DEPTH valid/ready register pipeline.
- Reset style: only control flops (per-stage valid, occupancy, ready-enable) carry reset; datapath flops carry none.
- Bubble-collapsing backpressure; synchronous flush input.
- Used as a generic retiming/slice stage between datapath blocks.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 4, number of register stages (>=1)
CW, $clog2(DEPTH+1), width of count (derived; not to be overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all stages
in_valid  input  1  upstream data valid
in_ready  output  1  pipeline accepts in_data this cycle
in_data  input  WIDTH  upstream data
out_valid  output  1  stage DEPTH-1 holds valid data
out_ready  input  1  downstream accepts out_data
out_data  output  WIDTH  contents of stage DEPTH-1
count  output  CW  number of occupied stages, 0..DEPTH

Behaviour:
- Reset:
  - Clock is clk; reset is rst_n, asynchronous, active-low.
  - Assertion immediately clears all stage valids v[0..DEPTH-1], count, and ready_en.
  - Data flops are not reset.
  - While rst_n is low: out_valid=0, count=0, in_ready=0.
- Ready enable:
  - ready_en (async reset 0) sets to 1 on the first clk edge after rst_n deasserts.
  - in_ready = ready_en & en[0] & ~flush.
  - Result: in_ready is low for the first cycle after reset release.
- Advance chain (combinational):
  - en[DEPTH] = out_ready.
  - en[i] = ~v[i] | en[i+1].
  - Empty stages always advance, so bubbles collapse.
- Stage update on each clk edge where en[i]=1:
  - v[i] <= v[i-1], d[i] <= d[i-1].
  - Stage 0 takes in_valid & in_ready and in_data.
  - Data registers may load unconditionally when en[i]; loaded contents are don't-care when the matching valid is 0.
- Outputs: out_valid = v[DEPTH-1] & ~flush; out_data = d[DEPTH-1].
- Latency:
  - Empty pipe: item accepted in cycle t presents on out_valid in cycle t+DEPTH.
  - Throughput: 1 item/cycle with out_ready held high.
- Ordering: strictly FIFO; no item is dropped or duplicated except by flush/reset.
- count:
  - +1 on input handshake only.
  - -1 on output handshake only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH and never underflows.
- Full: when count=DEPTH and out_ready=0, en[0]=0 so in_ready=0.
- Full with out_ready=1: in_ready=1 in the same cycle (simultaneous pop and push).
- Flush (priority over all handshakes):
  - During the flush cycle: in_ready=0, out_valid=0, no transfer counted.
  - At the next edge: all v <= 0, count <= 0.
  - Flush on an empty pipe is a no-op.
- Reset mid-operation: outputs drop asynchronously and all in-flight items are discarded; out_data keeps its last value (undefined after power-up).

Optional Feature:
- Macro: VALID_PIPE_DATA_RST_EN
- Defined:
  - All data flops d[0..DEPTH-1] get the same asynchronous active-low reset, clearing to 0.
  - out_data = 0 during and after reset until the first item reaches stage DEPTH-1.
- Undefined:
  - Data flops have no reset (smaller, faster flops).
  - out_data is unspecified after reset until first load.
  - The bench must not check out_data while out_valid=0.

Test Plan:
1. DEPTH=4, WIDTH=8: assert rst_n low mid-cycle, release -> out_valid=0 and count=0 immediately; in_ready=0 on first edge after release, 1 from the next cycle.
2. Stream 0x01..0x10 back-to-back with out_ready=1 -> 0x01 on out_valid 4 cycles after acceptance; one item/cycle in order; count steady at 4 once primed.
3. out_ready=0, push 0x11,0x22,0x33,0x44,0x55 -> count=4, in_ready=0, 0x55 held upstream; raise out_ready -> pops 0x11..0x55 in order, count returns to 0.
4. out_ready=0: push 0xA0, idle 2 cycles, push 0xB0 -> both collapse into stages 3,2; count=2, in_ready=1; release -> 0xA0 then 0xB0 on consecutive cycles.
5. count=3, out_ready=1, pulse flush one cycle with in_valid=1 -> no in/out handshake that cycle; next cycle count=0, out_valid=0; nothing emitted afterwards.
6. Build with VALID_PIPE_DATA_RST_EN, run 0xFF through, assert reset mid-stream -> out_data=0x00 and out_valid=0 asynchronously; without macro only out_valid/count are checked.
